// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file widths and index type
package riscv_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/rd_fifo.sv
// rd_fifo: in-order queue of outstanding load destinations with source-operand match
module rd_fifo #(
    parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [ADDR_WIDTH-1:0]         push_rd,
    input  logic                          pop,
    output logic [ADDR_WIDTH-1:0]         head_rd,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty,
    input  logic [ADDR_WIDTH-1:0]         rs1,
    input  logic [ADDR_WIDTH-1:0]         rs2,
    output logic                          hit
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0] wp, rp;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign do_push = push && count != CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign head_rd = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            vld <= '0;
        end else begin
            if (do_push) begin
                vld[wp] <= 1'b1;
                wp <= wp == PW'(DEPTH-1) ? '0 : wp + 1'b1;
            end
            if (do_pop) begin
                vld[rp] <= 1'b0;
                rp <= rp == PW'(DEPTH-1) ? '0 : rp + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= push_rd;
    // x0 never creates a hazard
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i] && ((rs1 != '0 && mem[i] == rs1) || (rs2 != '0 && mem[i] == rs2))) hit = 1'b1;
    end
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: arbitrates load returns and ALU results onto one register-file write port
module reg_writeback_unit #(
    parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int LQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  ld_issue,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    output logic                  ld_full,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  stall,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_rd,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  err
);
    localparam int CW = $clog2(LQ_DEPTH+1);
    logic [CW-1:0] lq_count;
    logic lq_empty, lq_hit, skid_valid, sel_v, alu_acc;
    logic [ADDR_WIDTH-1:0] head_rd, skid_rd, sel_rd;
    logic [DATA_WIDTH-1:0] skid_data, sel_data;
    assign alu_ready = !skid_valid;
    assign alu_acc = alu_valid && alu_ready;
    assign ld_full = lq_count == CW'(LQ_DEPTH);
    rd_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(LQ_DEPTH)) u_rd_fifo (
        .clk(clk), .rst_n(rst_n), .push(ld_issue), .push_rd(ld_rd), .pop(mem_rvalid),
        .head_rd(head_rd), .count(lq_count), .empty(lq_empty), .rs1(rs1), .rs2(rs2), .hit(lq_hit)
    );
    // a load response owns the port even when the queue is empty and nothing is written
    always_comb begin
        sel_v = mem_rvalid ? !lq_empty : skid_valid || alu_acc;
        sel_rd = mem_rvalid ? head_rd : skid_valid ? skid_rd : alu_rd;
        sel_data = mem_rvalid ? mem_rdata : skid_valid ? skid_data : alu_data;
        stall = lq_hit || (skid_valid && ((rs1 != '0 && rs1 == skid_rd) || (rs2 != '0 && rs2 == skid_rd)));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en <= 1'b0;
            wr_rd <= '0;
            wr_data <= '0;
            err <= 1'b0;
            skid_valid <= 1'b0;
            skid_rd <= '0;
            skid_data <= '0;
        end else begin
            wr_en <= sel_v && sel_rd != '0;
            wr_rd <= sel_rd;
            wr_data <= sel_data;
            if ((ld_issue && ld_full) || (mem_rvalid && lq_empty)) err <= 1'b1;
            if (mem_rvalid && alu_acc) begin
                skid_valid <= 1'b1;
                skid_rd <= alu_rd;
                skid_data <= alu_data;
            end else if (!mem_rvalid) skid_valid <= 1'b0;
        end
    end
endmodule
